// File: rtl/booth_pp_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : booth_pp_gen_if
// Description : Operand-in / partial-product-out bus of the Booth PP generator.
// Revision    : 1.0 - initial release
// ============================================================================
interface booth_pp_gen_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_x;
    logic [31:0] in_y;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] P_0;
    logic [63:0] P_1;
    logic [63:0] P_2;
    logic [63:0] P_3;
    logic [63:0] P_4;
    logic [63:0] P_5;
    logic [63:0] P_6;
    logic [63:0] P_7;
    logic [63:0] P_8;
    logic [63:0] P_9;
    logic [63:0] P_10;
    logic [63:0] P_11;
    logic [63:0] P_12;
    logic [63:0] P_13;
    logic [63:0] P_14;
    logic [63:0] P_15;
    logic [15:0] NEG;

    // master = the surrounding datapath (operand source and PP sink)
    modport master (
        output in_valid, in_x, in_y, out_ready,
        input  in_ready, out_valid, NEG,
        input  P_0, P_1, P_2, P_3, P_4, P_5, P_6, P_7,
        input  P_8, P_9, P_10, P_11, P_12, P_13, P_14, P_15
    );

    modport slave (
        input  in_valid, in_x, in_y, out_ready,
        output in_ready, out_valid, NEG,
        output P_0, P_1, P_2, P_3, P_4, P_5, P_6, P_7,
        output P_8, P_9, P_10, P_11, P_12, P_13, P_14, P_15
    );
endinterface
`default_nettype wire

// File: rtl/booth_pp_gen.sv
`default_nettype none
// ============================================================================
// Module      : booth_pp_gen
// Description : Radix-4 Booth partial-product generator, 32x32 signed, two
//               pipeline stages (recode, form). BOOTH_PP_SKID_EN selects a
//               registered in_ready backed by a 1-entry input skid register.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_pp_gen (
    input wire            clk,
    input wire            rst,
    booth_pp_gen_if.slave bus
);
    localparam int c_NUM_PP = 16;

    logic                w_adv1;
    logic                w_adv2;
    logic                w_s1_take;
    logic [31:0]         w_s1_x;
    logic [31:0]         w_s1_y;
    logic [32:0]         w_y_ext;
    logic [c_NUM_PP-1:0] w_one;
    logic [c_NUM_PP-1:0] w_two;
    logic [c_NUM_PP-1:0] w_neg;
    logic [63:0]         w_pp [c_NUM_PP];

    logic                r_v1;
    logic                r_v2;
    logic [63:0]         r_x;
    logic [c_NUM_PP-1:0] r_one;
    logic [c_NUM_PP-1:0] r_two;
    logic [c_NUM_PP-1:0] r_neg;
    logic [63:0]         r_p [c_NUM_PP];
    logic [c_NUM_PP-1:0] r_neg_out;

    assign w_adv2 = !r_v2 || bus.out_ready;
    assign w_adv1 = !r_v1 || w_adv2;

`ifdef BOOTH_PP_SKID_EN
    logic        r_skid_v;
    logic        r_in_ready;
    logic [31:0] r_skid_x;
    logic [31:0] r_skid_y;
    logic        w_in_acc;
    logic        w_skid_v_nxt;

    // A parked beat is older than anything on the bus, so it enters stage 1 first.
    assign w_in_acc     = bus.in_valid && r_in_ready;
    assign w_s1_take    = r_skid_v || w_in_acc;
    assign w_s1_x       = r_skid_v ? r_skid_x : bus.in_x;
    assign w_s1_y       = r_skid_v ? r_skid_y : bus.in_y;
    assign w_skid_v_nxt = !w_adv1 && (r_skid_v || w_in_acc);
    assign bus.in_ready = r_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_skid_v   <= 1'b0;
            r_in_ready <= 1'b1;
        end else begin
            r_skid_v   <= w_skid_v_nxt;
            r_in_ready <= !w_skid_v_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_acc && !w_adv1) begin
            r_skid_x <= bus.in_x;
            r_skid_y <= bus.in_y;
        end
    end
`else
    assign w_s1_take    = bus.in_valid && w_adv1;
    assign w_s1_x       = bus.in_x;
    assign w_s1_y       = bus.in_y;
    assign bus.in_ready = w_adv1;
`endif

    // Stage 1: recode overlapping triplets {y[2i+1], y[2i], y[2i-1]}, y[-1] = 0.
    assign w_y_ext = {w_s1_y, 1'b0};

    for (genvar i = 0; i < c_NUM_PP; i++) begin : g_recode
        logic [2:0] w_grp;
        assign w_grp    = w_y_ext[2*i+2 : 2*i];
        assign w_one[i] = w_grp[1] ^ w_grp[0];
        assign w_two[i] = (w_grp == 3'b011) || (w_grp == 3'b100);
        assign w_neg[i] = w_grp[2] && !(w_grp[1] && w_grp[0]);
    end

    // Stage 2: negation is one's complement here; the +1 travels on NEG.
    for (genvar i = 0; i < c_NUM_PP; i++) begin : g_form
        logic [63:0] w_mag;
        assign w_mag   = r_one[i] ? r_x : (r_two[i] ? {r_x[62:0], 1'b0} : 64'd0);
        assign w_pp[i] = (r_neg[i] ? ~w_mag : w_mag) << (2 * i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else begin
            if (w_adv1) begin
                r_v1 <= w_s1_take;
            end
            if (w_adv2) begin
                r_v2 <= r_v1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_adv1 && w_s1_take) begin
            r_x   <= {{32{w_s1_x[31]}}, w_s1_x};
            r_one <= w_one;
            r_two <= w_two;
            r_neg <= w_neg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_NUM_PP; i++) begin
                r_p[i] <= 64'd0;
            end
            r_neg_out <= '0;
        end else if (w_adv2 && r_v1) begin
            for (int i = 0; i < c_NUM_PP; i++) begin
                r_p[i] <= w_pp[i];
            end
            r_neg_out <= r_neg;
        end
    end

    assign bus.out_valid = r_v2;
    assign bus.NEG       = r_neg_out;
    assign bus.P_0       = r_p[0];
    assign bus.P_1       = r_p[1];
    assign bus.P_2       = r_p[2];
    assign bus.P_3       = r_p[3];
    assign bus.P_4       = r_p[4];
    assign bus.P_5       = r_p[5];
    assign bus.P_6       = r_p[6];
    assign bus.P_7       = r_p[7];
    assign bus.P_8       = r_p[8];
    assign bus.P_9       = r_p[9];
    assign bus.P_10      = r_p[10];
    assign bus.P_11      = r_p[11];
    assign bus.P_12      = r_p[12];
    assign bus.P_13      = r_p[13];
    assign bus.P_14      = r_p[14];
    assign bus.P_15      = r_p[15];
endmodule
`default_nettype wire

// File: tb/tb_booth_pp_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_pp_gen
// Description : Self-checking bench for booth_pp_gen (directed + random).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_pp_gen;
`ifdef BOOTH_PP_SKID_EN
    localparam int c_STALL_ACC = 3;
`else
    localparam int c_STALL_ACC = 2;
`endif

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        int          cyc;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    booth_pp_gen_if bus ();

    booth_pp_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [63:0] tb_p [16];
    always_comb begin
        tb_p[0]  = bus.P_0;  tb_p[1]  = bus.P_1;  tb_p[2]  = bus.P_2;  tb_p[3]  = bus.P_3;
        tb_p[4]  = bus.P_4;  tb_p[5]  = bus.P_5;  tb_p[6]  = bus.P_6;  tb_p[7]  = bus.P_7;
        tb_p[8]  = bus.P_8;  tb_p[9]  = bus.P_9;  tb_p[10] = bus.P_10; tb_p[11] = bus.P_11;
        tb_p[12] = bus.P_12; tb_p[13] = bus.P_13; tb_p[14] = bus.P_14; tb_p[15] = bus.P_15;
    end

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          n_acc = 0;
    int          n_out = 0;
    int          src_left = 0;
    int          src_mode = 0;
    int          vin_pct = 100;
    int          rdy_pct = 100;
    int          seq_k = 0;
    bit          rdy_rand = 1'b0;
    beat_t       q [$];
    logic [63:0] last_p [16];
    logic [15:0] last_neg;
    int          last_lat = 0;
    int          last_out_cyc = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] a;
        logic signed [63:0] b;
        a = {{32{x[31]}}, x};
        b = {{32{y[31]}}, y};
        return a * b;
    endfunction

    function automatic logic [63:0] pp_sum();
        logic [63:0] s;
        s = 64'd0;
        for (int i = 0; i < 16; i++) begin
            s += tb_p[i];
            if (bus.NEG[i]) s += 64'd1 << (2 * i);
        end
        return s;
    endfunction

    function automatic logic [63:0] out_sig();
        logic [63:0] s;
        s = {47'd0, bus.out_valid, bus.NEG};
        for (int i = 0; i < 16; i++) begin
            s = {s[62:0], s[63]} ^ tb_p[i];
        end
        return s;
    endfunction

    task automatic present();
        if (src_mode == 1) begin
            bus.in_x = ($urandom_range(7) == 0) ? 32'h8000_0000 : $urandom;
            bus.in_y = ($urandom_range(7) == 0) ? 32'h8000_0000 : $urandom;
        end else begin
            bus.in_x = 32'h0001_0000 + 32'(seq_k);
            bus.in_y = 32'hFFFF_FFF0 - 32'(3 * seq_k);
            seq_k++;
        end
        bus.in_valid = 1'b1;
    endtask

    // One clock: observe handshakes mid-cycle, then update stimulus after the edge.
    task automatic step();
        bit    acc;
        beat_t b;
        @(negedge clk);
        acc = bus.in_valid && bus.in_ready;
        if (acc) begin
            b.x = bus.in_x; b.y = bus.in_y; b.cyc = cyc;
            q.push_back(b);
            n_acc++;
        end
        if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                chk("spurious_beat", 64'd1, 64'd0);
            end else begin
                b = q.pop_front();
                chk("pp_sum", pp_sum(), ref_prod(b.x, b.y));
                last_lat = cyc - b.cyc;
            end
            last_p       = tb_p;
            last_neg     = bus.NEG;
            last_out_cyc = cyc;
            n_out++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (acc && src_left > 0) src_left--;
        if (acc || !bus.in_valid) begin
            if (src_left > 0 && int'($urandom_range(99)) < vin_pct) present();
            else bus.in_valid = 1'b0;
        end
        if (rdy_rand) bus.out_ready = (int'($urandom_range(99)) < rdy_pct);
    endtask

    task automatic wait_out(input int bound);
        int n0;
        int k;
        n0 = n_out;
        k  = 0;
        while (n_out == n0 && k < bound) begin
            step();
            k++;
        end
        if (n_out == n0) chk("timeout_out", 64'd1, 64'd0);
    endtask

    task automatic drain(input int bound);
        int k;
        k = 0;
        rdy_rand = 1'b0;
        bus.out_ready = 1'b1;
        while ((q.size() > 0 || bus.in_valid) && k < bound) begin
            step();
            k++;
        end
        if (q.size() > 0 || bus.in_valid) chk("timeout_drain", 64'd1, 64'd0);
    endtask

    task automatic run_dir(input string tag, input logic [31:0] x, input logic [31:0] y,
                           input int ia, input logic [63:0] va,
                           input int ib, input logic [63:0] vb, input logic [15:0] en);
        logic [63:0] e;
        bus.in_x      = x;
        bus.in_y      = y;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        src_left      = 1;
        wait_out(10);
        for (int i = 0; i < 16; i++) begin
            e = (i == ia) ? va : ((i == ib) ? vb : 64'd0);
            chk($sformatf("%s_p%0d", tag, i), last_p[i], e);
        end
        chk({tag, "_neg"}, 64'(last_neg), 64'(en));
        chk({tag, "_lat"}, 64'(last_lat), 64'd2);
    endtask

    initial begin
        int          n0;
        int          a0;
        int          first;
        int          k;
        bit          have_ref;
        logic [63:0] ref_sig;

        bus.in_valid  = 1'b0;
        bus.in_x      = 32'd0;
        bus.in_y      = 32'd0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_neg", 64'(bus.NEG), 64'd0);
        for (int i = 0; i < 16; i++) chk($sformatf("rst_p%0d", i), tb_p[i], 64'd0);

        // Directed vectors, expectations worked out by hand.
        run_dir("x3y5",   32'd3,          32'd5,          0, 64'd3, 1, 64'd12, 16'h0000);
        run_dir("m1_min", 32'hFFFF_FFFF,  32'h8000_0000, 15, 64'h0000_0000_4000_0000, -1, 64'd0, 16'h8000);
        run_dir("min_min",32'h8000_0000,  32'h8000_0000, 15, 64'h3FFF_FFFF_C000_0000, -1, 64'd0, 16'h8000);
        run_dir("x7_m1",  32'd7,          32'hFFFF_FFFF,  0, 64'hFFFF_FFFF_FFFF_FFF8, -1, 64'd0, 16'h0001);
        run_dir("x5y2",   32'd5,          32'd2,          0, 64'hFFFF_FFFF_FFFF_FFF5, 1, 64'h14, 16'h0001);
        run_dir("x5y6",   32'd5,          32'd6,          0, 64'hFFFF_FFFF_FFFF_FFF5, 1, 64'h28, 16'h0001);

        // Eight back-to-back beats with the sink always ready.
        bus.out_ready = 1'b1;
        src_mode = 0; vin_pct = 100; seq_k = 0;
        src_left = 8;
        present();
        n0 = n_out; first = -1; k = 0;
        while (n_out - n0 < 8 && k < 40) begin
            step();
            if (first < 0 && n_out > n0) first = last_out_cyc;
            k++;
        end
        chk("b2b_count", 64'(n_out - n0), 64'd8);
        chk("b2b_span", 64'(last_out_cyc - first), 64'd7);
        drain(20);

        // Sink stalled for five cycles with the source always offering.
        bus.out_ready = 1'b0;
        src_left = 10;
        present();
        a0 = n_acc; have_ref = 1'b0; ref_sig = 64'd0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.out_valid) begin
                if (have_ref) chk("stall_hold", out_sig(), ref_sig);
                else begin ref_sig = out_sig(); have_ref = 1'b1; end
            end
        end
        chk("stall_accepts", 64'(n_acc - a0), 64'(c_STALL_ACC));
        drain(60);
        chk("stall_total", 64'(n_acc - a0), 64'd10);

        // Reset with two beats in flight: neither may ever appear.
        bus.out_ready = 1'b1;
        src_left = 2;
        present();
        step();
        step();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        src_left = 0;
        rst = 1'b1;
        q.delete();
        step();
        rst = 1'b0;
        chk("rst_flush_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_flush_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        n0 = n_out;
        repeat (6) step();
        chk("rst_flush_none", 64'(n_out - n0), 64'd0);

        // Random operands with random valid and ready.
        src_mode = 1; vin_pct = 70; rdy_pct = 70; rdy_rand = 1'b1;
        src_left = 1000000;
        a0 = n_acc; n0 = n_out;
        present();
        repeat (20000) step();
        src_left = 0;
        drain(100);
        chk("rand_count", 64'(n_out - n0), 64'(n_acc - a0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
